// File: rtl/core_io_unit.sv
// I/O subsystem: power-on sanity reset sequencer, 32-bit GPIO bank with MMIO access,
// and an 8-channel H-bridge PWM generator.
module core_io_unit #(
  parameter logic [15:0] SANITY_TARGET = 16'hAA55,
  parameter int unsigned PWM_BITS      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic [31:0] bus_rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_dir,
  output logic [7:0]  hbr_pwm,
  output logic        core_reset_out
);

  logic [15:0]         r_san_cnt;
  logic                r_ready;
  logic [31:0]         r_gpio_out;
  logic [31:0]         r_gpio_dir;
  logic [31:0]         r_sync1;
  logic [31:0]         r_sync2;
  logic [31:0]         r_duty_lo;
  logic [31:0]         r_duty_hi;
  logic [15:0]         r_presc;
  logic [15:0]         r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [7:0]          r_hbr;
  logic [31:0]         r_rdata;

  logic [31:0]         w_rd_val;
  logic [63:0]         w_duty_all;
  logic [7:0]          w_hbr_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_san_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      if (r_san_cnt != SANITY_TARGET) r_san_cnt <= r_san_cnt + 16'd1;
      r_ready <= (r_san_cnt == SANITY_TARGET);
    end
  end

  assign core_reset_out = !r_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gpio_out <= '0;
      r_gpio_dir <= '0;
      r_duty_lo  <= '0;
      r_duty_hi  <= '0;
      r_presc    <= '0;
    end else if (bus_wr && r_ready) begin
      case (bus_addr)
        4'h0:    r_gpio_out <= bus_wdata;
        4'h1:    r_gpio_dir <= bus_wdata;
        4'h4:    r_duty_lo  <= bus_wdata;
        4'h5:    r_duty_hi  <= bus_wdata;
        4'h6:    r_presc    <= bus_wdata[15:0];
        default: ;
      endcase
    end
  end

  // Only STATUS is visible before the sequencer releases the core.
  always_comb begin
    w_rd_val = '0;
    case (bus_addr)
      4'h0:    w_rd_val = r_gpio_out;
      4'h1:    w_rd_val = r_gpio_dir;
      4'h2:    w_rd_val = r_sync2;
      4'h3:    w_rd_val = {31'b0, r_ready};
      4'h4:    w_rd_val = r_duty_lo;
      4'h5:    w_rd_val = r_duty_hi;
      4'h6:    w_rd_val = {16'b0, r_presc};
      default: w_rd_val = '0;
    endcase
    if (!r_ready && bus_addr != 4'h3) w_rd_val = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (bus_rd) begin
      r_rdata <= w_rd_val;
    end
  end

  assign w_duty_all = {r_duty_hi, r_duty_lo};

  always_comb begin
    w_hbr_next = '0;
    for (int n = 0; n < 8; n++) begin
      w_hbr_next[n] = (r_pwm_cnt < w_duty_all[n*8 +: PWM_BITS]);
    end
  end

  // >= lets a prescale lowered below the running count wrap immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
      r_hbr     <= '0;
    end else if (!r_ready) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
      r_hbr     <= '0;
    end else begin
      if (r_pre_cnt >= r_presc) begin
        r_pre_cnt <= '0;
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end else begin
        r_pre_cnt <= r_pre_cnt + 16'd1;
      end
      r_hbr <= w_hbr_next;
    end
  end

  assign bus_rdata = r_rdata;
  assign gpio_out  = r_gpio_out;
  assign gpio_dir  = r_gpio_dir;
  assign hbr_pwm   = r_hbr;

endmodule

// File: tb/tb_core_io_unit.sv
// Self-checking bench for core_io_unit: table-driven register vectors plus
// hand-written sequences for reset sequencing, GPIO synchronizer and PWM.
module tb_core_io_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic [7:0]  hbr_pwm;
  logic        core_reset_out;

  int errs = 0;
  int checks = 0;

  core_io_unit #(
    .SANITY_TARGET(16'd16),
    .PWM_BITS     (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wr        (bus_wr),
    .bus_rd        (bus_rd),
    .bus_rdata     (bus_rdata),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .gpio_dir      (gpio_dir),
    .hbr_pwm       (hbr_pwm),
    .core_reset_out(core_reset_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic [31:0] e_out;
    logic [31:0] e_dir;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    bus_rd = 1'b1; bus_addr = a;
    tick();
    bus_rd = 1'b0;
  endtask

  // Counts edges after release until core_reset_out drops; bounded.
  task automatic wait_ready(input int start, output int cyc);
    cyc = start;
    while (core_reset_out && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;
  int cnt[8];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'h1, 32'h0000FFFF, 32'h0,        32'hDEADBEEF, 32'h0000FFFF};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0000FFFF};
    vecs[3]  = '{1'b0, 1'b1, 4'h1, 32'h0,        32'h0000FFFF, 32'hDEADBEEF, 32'h0000FFFF};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 32'h11111111, 32'hDEADBEEF, 32'h11111111, 32'h0000FFFF};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 32'h0,        32'h11111111, 32'h11111111, 32'h0000FFFF};
    vecs[6]  = '{1'b1, 1'b0, 4'h6, 32'hFFFFFFFF, 32'h11111111, 32'h11111111, 32'h0000FFFF};
    vecs[7]  = '{1'b0, 1'b1, 4'h6, 32'h0,        32'h0000FFFF, 32'h11111111, 32'h0000FFFF};
    vecs[8]  = '{1'b1, 1'b0, 4'h7, 32'h0000005A, 32'h0000FFFF, 32'h11111111, 32'h0000FFFF};
    vecs[9]  = '{1'b0, 1'b1, 4'h7, 32'h0,        32'h0,        32'h11111111, 32'h0000FFFF};
    vecs[10] = '{1'b1, 1'b0, 4'h3, 32'hFFFFFFFF, 32'h0,        32'h11111111, 32'h0000FFFF};
    vecs[11] = '{1'b0, 1'b1, 4'h3, 32'h0,        32'h1,        32'h11111111, 32'h0000FFFF};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 32'h0000FFFF};
    vecs[13] = '{1'b0, 1'b1, 4'hF, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0000FFFF};
    vecs[14] = '{1'b1, 1'b0, 4'h4, 32'h12345678, 32'h0,        32'hDEADBEEF, 32'h0000FFFF};
    vecs[15] = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h12345678, 32'hDEADBEEF, 32'h0000FFFF};
    vecs[16] = '{1'b1, 1'b0, 4'h5, 32'h9ABCDEF0, 32'h12345678, 32'hDEADBEEF, 32'h0000FFFF};
    vecs[17] = '{1'b0, 1'b1, 4'h5, 32'h0,        32'h9ABCDEF0, 32'hDEADBEEF, 32'h0000FFFF};

    reset = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wr = 1'b0; bus_rd = 1'b0; gpio_in = '0;
    repeat (3) tick();
    chk("rst_core_reset_out", {31'b0, core_reset_out}, 32'h1);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_dir", gpio_dir, 32'h0);
    chk("rst_hbr", {24'b0, hbr_pwm}, 32'h0);

    // Release between edges; the next edge is cycle 1.
    reset = 1'b1;
    bus_write(4'h0, 32'hFFFFFFFF);
    chk("early_wr_gpio_out", gpio_out, 32'h0);
    bus_read(4'h0);
    chk("early_rd_gpio_out", bus_rdata, 32'h0);
    bus_read(4'h3);
    chk("early_status", bus_rdata, 32'h0);
    chk("early_core_reset", {31'b0, core_reset_out}, 32'h1);
    wait_ready(3, cyc);
    chk("ready_cycle", cyc, 32'd17);
    bus_read(4'h3);
    chk("status_ready", bus_rdata, 32'h1);
    bus_read(4'h0);
    chk("gpio_out_after_ready", bus_rdata, 32'h0);

    for (int i = 0; i < 18; i++) begin
      bus_wr = vecs[i].wr; bus_rd = vecs[i].rd;
      bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
      tick();
      bus_wr = 1'b0; bus_rd = 1'b0;
      chk($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].e_out);
      chk($sformatf("vec%0d_gpio_dir", i), gpio_dir, vecs[i].e_dir);
    end

    // Pin change sampled at edge E; reads at E+1 see old, at E+2 see new.
    gpio_in = 32'h12345678;
    tick();
    bus_read(4'h2);
    chk("gpio_in_1clk", bus_rdata, 32'h0);
    bus_read(4'h2);
    chk("gpio_in_2clk", bus_rdata, 32'h12345678);

    bus_write(4'h6, 32'h0);
    bus_write(4'h5, 32'h0);
    bus_write(4'h4, 32'h00FF8040);
    repeat (3) tick();
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      for (int c = 0; c < 8; c++) cnt[c] += int'(hbr_pwm[c]);
    end
    chk("pwm_p0_ch0", cnt[0], 32'd64);
    chk("pwm_p0_ch1", cnt[1], 32'd128);
    chk("pwm_p0_ch2", cnt[2], 32'd255);
    chk("pwm_p0_ch3", cnt[3], 32'd0);
    chk("pwm_p0_hi", cnt[4] + cnt[5] + cnt[6] + cnt[7], 32'd0);

    bus_write(4'h6, 32'h3);
    bus_write(4'h4, 32'h00000080);
    repeat (5) tick();
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      for (int c = 0; c < 8; c++) cnt[c] += int'(hbr_pwm[c]);
    end
    chk("pwm_p3_ch0", cnt[0], 32'd512);
    chk("pwm_p3_ch1", cnt[1], 32'd0);

    // Asynchronous reset mid-PWM.
    reset = 1'b0;
    #1;
    chk("midrst_hbr", {24'b0, hbr_pwm}, 32'h0);
    chk("midrst_gpio_out", gpio_out, 32'h0);
    chk("midrst_gpio_dir", gpio_dir, 32'h0);
    chk("midrst_rdata", bus_rdata, 32'h0);
    chk("midrst_core_reset", {31'b0, core_reset_out}, 32'h1);
    repeat (2) tick();
    reset = 1'b1;
    wait_ready(0, cyc);
    chk("reready_cycle", cyc, 32'd17);
    bus_read(4'h4);
    chk("duty_after_rst", bus_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
